// File: rtl/loopback_test_sequencer_if.sv
// rtl/loopback_test_sequencer_if.sv - send/receive controller handshake bundle for the loopback sequencer
interface loopback_test_sequencer_if #(
    parameter int ADDR_W = 25
);
    logic [ADDR_W-1:0] send_1_start_ram_addr;
    logic              send_1_cmd_send;
    logic [ADDR_W-1:0] send_2_start_ram_addr;
    logic              send_2_cmd_send;
    logic              data_saved_1;
    logic              data_saved_2;

    modport master (
        output send_1_start_ram_addr,
        output send_1_cmd_send,
        output send_2_start_ram_addr,
        output send_2_cmd_send,
        input  data_saved_1,
        input  data_saved_2
    );

    modport slave (
        input  send_1_start_ram_addr,
        input  send_1_cmd_send,
        input  send_2_start_ram_addr,
        input  send_2_cmd_send,
        output data_saved_1,
        output data_saved_2
    );
endinterface

// File: rtl/loopback_test_sequencer.sv
// rtl/loopback_test_sequencer.sv - alternating-port loopback packet test sequencer with pass/fail tally
module loopback_test_sequencer #(
    parameter int          NUM_PACKETS    = 16,
    parameter int          GAP_CYCLES     = 1000,
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter logic [24:0] ADDR_1         = 25'h0000000,
    parameter logic [24:0] ADDR_2         = 25'h0000800
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mac_inited,
    input  logic                       start,
    loopback_test_sequencer_if.master  lb,
    output logic                       busy,
    output logic                       done,
    output logic                       aborted,
    output logic [15:0]                pass_count,
    output logic [15:0]                fail_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_RX,
        S_GAP,
        S_DONE
    } state_t;

    // A zero gap still spends one cycle in GAP so the index update has a home.
    localparam int          GAP_LEN  = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
    localparam logic [31:0] GAP_LAST = 32'(GAP_LEN - 1);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0] IDX_LAST = 17'(NUM_PACKETS - 1);

    state_t      state;
    state_t      state_nxt;
    logic [16:0] pkt_idx;
    logic [31:0] timeout_cnt;
    logic [31:0] gap_cnt;
    logic        ds1_q;
    logic        ds2_q;

    logic edge_1;
    logic edge_2;
    logic exp_edge;
    logic unexp_edge;
    logic timed_out;
    logic gap_last;
    logic pkt_last;
    logic start_ok;

    assign edge_1     = lb.data_saved_1 & ~ds1_q;
    assign edge_2     = lb.data_saved_2 & ~ds2_q;
    // Even packets leave on port 1 and come back on port 2; odd ones the reverse.
    assign exp_edge   = pkt_idx[0] ? edge_1 : edge_2;
    assign unexp_edge = pkt_idx[0] ? edge_2 : edge_1;
    assign timed_out  = (timeout_cnt >= TO_LAST);
    assign gap_last   = (gap_cnt >= GAP_LAST);
    assign pkt_last   = (pkt_idx == IDX_LAST);
    assign start_ok   = start & mac_inited;

    assign lb.send_1_start_ram_addr = ADDR_1;
    assign lb.send_2_start_ram_addr = ADDR_2;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_ok) state_nxt = S_SEND;
            end
            S_SEND: begin
                state_nxt = mac_inited ? S_WAIT_RX : S_DONE;
            end
            S_WAIT_RX: begin
                if (!mac_inited)                               state_nxt = S_DONE;
                else if (exp_edge || unexp_edge || timed_out)  state_nxt = S_GAP;
            end
            S_GAP: begin
                if (!mac_inited)   state_nxt = S_DONE;
                else if (gap_last) state_nxt = pkt_last ? S_DONE : S_SEND;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy               = (state == S_SEND) || (state == S_WAIT_RX) || (state == S_GAP);
        done               = (state == S_DONE);
        lb.send_1_cmd_send = (state == S_SEND) && mac_inited && !pkt_idx[0];
        lb.send_2_cmd_send = (state == S_SEND) && mac_inited &&  pkt_idx[0];
    end

    // A MAC drop wins over every other event so the tally freezes at the abort point.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_idx     <= '0;
            timeout_cnt <= '0;
            gap_cnt     <= '0;
            ds1_q       <= 1'b0;
            ds2_q       <= 1'b0;
            aborted     <= 1'b0;
            pass_count  <= '0;
            fail_count  <= '0;
        end else begin
            ds1_q <= lb.data_saved_1;
            ds2_q <= lb.data_saved_2;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        pkt_idx     <= '0;
                        timeout_cnt <= '0;
                        gap_cnt     <= '0;
                        aborted     <= 1'b0;
                        pass_count  <= '0;
                        fail_count  <= '0;
                    end
                end
                S_SEND: begin
                    timeout_cnt <= '0;
                    if (!mac_inited) aborted <= 1'b1;
                end
                S_WAIT_RX: begin
                    gap_cnt <= '0;
                    if (!mac_inited)     aborted     <= 1'b1;
                    else if (unexp_edge) fail_count  <= sat_inc(fail_count);
                    else if (exp_edge)   pass_count  <= sat_inc(pass_count);
                    else if (timed_out)  fail_count  <= sat_inc(fail_count);
                    else                 timeout_cnt <= timeout_cnt + 32'd1;
                end
                S_GAP: begin
                    if (!mac_inited) begin
                        aborted <= 1'b1;
                    end else if (gap_last) begin
                        pkt_idx <= pkt_idx + 17'd1;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_loopback_test_sequencer.sv
// tb/tb_loopback_test_sequencer.sv - scoreboard bench for loopback_test_sequencer
module tb_loopback_test_sequencer;

    localparam logic [24:0] A1 = 25'h0000100;
    localparam logic [24:0] A2 = 25'h0000800;

    logic        clk = 1'b0;
    logic        reset;
    logic        mac_inited;
    logic        start;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] pass_count;
    logic [15:0] fail_count;

    logic echo_en  = 1'b0;
    logic echo_ds1 = 1'b0;
    logic echo_ds2 = 1'b0;
    logic man_ds1  = 1'b0;
    logic man_ds2  = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int mon_exp;
    int mon_act;
    int echo_port;
    int port;
    int n;

    loopback_test_sequencer_if lb();

    assign lb.data_saved_1 = echo_ds1 | man_ds1;
    assign lb.data_saved_2 = echo_ds2 | man_ds2;

    loopback_test_sequencer #(
        .NUM_PACKETS    (4),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (20),
        .ADDR_1         (A1),
        .ADDR_2         (A2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mac_inited (mac_inited),
        .start      (start),
        .lb         (lb),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .pass_count (pass_count),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every issued send command is matched against the queued port order.
    always @(negedge clk) begin
        if (lb.send_1_cmd_send || lb.send_2_cmd_send) begin
            chk("cmd_exclusive", 32'(lb.send_1_cmd_send & lb.send_2_cmd_send), 32'd0);
            chk("addr_1_at_cmd", 32'(lb.send_1_start_ram_addr), 32'(A1));
            chk("addr_2_at_cmd", 32'(lb.send_2_start_ram_addr), 32'(A2));
            mon_act = lb.send_1_cmd_send ? 1 : 2;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL cmd_unexpected: port %0d issued, none expected at %0t", mon_act, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("cmd_port", 32'(mon_act), 32'(mon_exp));
            end
        end
    end

    // Loopback model: echo each send on the opposite port ten cycles later.
    always begin
        @(negedge clk);
        if (echo_en && (lb.send_1_cmd_send || lb.send_2_cmd_send)) begin
            echo_port = lb.send_1_cmd_send ? 2 : 1;
            repeat (10) @(negedge clk);
            if (echo_port == 1) echo_ds1 = 1'b1;
            else                echo_ds2 = 1'b1;
            @(negedge clk);
            echo_ds1 = 1'b0;
            echo_ds2 = 1'b0;
        end
    end

    task automatic push4();
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(1);
        exp_q.push_back(2);
    endtask

    task automatic start_run();
        @(negedge clk);
        mac_inited = 1'b1;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_done_clr", 32'(done), 32'd0);
        chk("start_abort_clr", 32'(aborted), 32'd0);
        chk("start_pass_clr", 32'(pass_count), 32'd0);
        chk("start_fail_clr", 32'(fail_count), 32'd0);
    endtask

    task automatic wait_cmd(output int p);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(lb.send_1_cmd_send || lb.send_2_cmd_send) && k < 200);
        p = lb.send_1_cmd_send ? 1 : (lb.send_2_cmd_send ? 2 : 0);
        if (p == 0) chk("cmd_wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic next_evt(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(lb.send_1_cmd_send || lb.send_2_cmd_send || done) && cnt < 300);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 600) begin
            @(negedge clk);
            k++;
        end
        chk("run_done", 32'(done), 32'd1);
        chk("run_not_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        mac_inited = 1'b0;
        start      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr_1", 32'(lb.send_1_start_ram_addr), 32'(A1));
        chk("rst_addr_2", 32'(lb.send_2_start_ram_addr), 32'(A2));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_aborted", 32'(aborted), 32'd0);
        chk("rst_pass", 32'(pass_count), 32'd0);
        chk("rst_fail", 32'(fail_count), 32'd0);
        chk("rst_cmd", 32'({lb.send_1_cmd_send, lb.send_2_cmd_send}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Normal loopback: order 1,2,1,2, 1 SEND + 10 WAIT_RX + 2 GAP per packet.
        echo_en = 1'b1;
        push4();
        start_run();
        wait_cmd(port);
        for (int i = 0; i < 3; i++) begin
            next_evt(n);
            chk("t1_interval", 32'(n), 32'd13);
        end
        next_evt(n);
        chk("t1_last_to_done", 32'(n), 32'd13);
        wait_done();
        chk("t1_pass", 32'(pass_count), 32'd4);
        chk("t1_fail", 32'(fail_count), 32'd0);
        chk("t1_q_drained", 32'(exp_q.size()), 32'd0);
        echo_en = 1'b0;

        // No echoes: exactly 20 WAIT_RX cycles per packet then timeout.
        push4();
        start_run();
        wait_cmd(port);
        for (int i = 0; i < 4; i++) begin
            next_evt(n);
            chk("t2_interval", 32'(n), 32'd23);
        end
        wait_done();
        chk("t2_pass", 32'(pass_count), 32'd0);
        chk("t2_fail", 32'(fail_count), 32'd4);
        chk("t2_q_drained", 32'(exp_q.size()), 32'd0);

        // Packet 0 echoed on both ports in the same cycle counts one failure.
        push4();
        start_run();
        wait_cmd(port);
        repeat (2) @(negedge clk);
        echo_en = 1'b1;
        repeat (3) @(negedge clk);
        man_ds1 = 1'b1;
        man_ds2 = 1'b1;
        @(negedge clk);
        man_ds1 = 1'b0;
        man_ds2 = 1'b0;
        chk("t3_pkt0_fail", 32'(fail_count), 32'd1);
        chk("t3_pkt0_pass", 32'(pass_count), 32'd0);
        wait_done();
        chk("t3_pass", 32'(pass_count), 32'd3);
        chk("t3_fail", 32'(fail_count), 32'd1);
        chk("t3_q_drained", 32'(exp_q.size()), 32'd0);

        // MAC drop in WAIT_RX of packet 1; the late echo must not be counted.
        exp_q.push_back(1);
        exp_q.push_back(2);
        start_run();
        wait_cmd(port);
        wait_cmd(port);
        repeat (3) @(negedge clk);
        mac_inited = 1'b0;
        @(posedge clk);
        #1;
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_aborted", 32'(aborted), 32'd1);
        chk("t4_pass", 32'(pass_count), 32'd1);
        chk("t4_fail", 32'(fail_count), 32'd0);
        repeat (40) @(negedge clk);
        chk("t4_pass_frozen", 32'(pass_count), 32'd1);
        chk("t4_fail_frozen", 32'(fail_count), 32'd0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("t4_nomac_done", 32'(done), 32'd1);
        chk("t4_nomac_busy", 32'(busy), 32'd0);
        chk("t4_nomac_aborted", 32'(aborted), 32'd1);
        chk("t4_q_drained", 32'(exp_q.size()), 32'd0);

        // Reset pulse during GAP of packet 2, then a full fresh run.
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(1);
        start_run();
        wait_cmd(port);
        wait_cmd(port);
        wait_cmd(port);
        repeat (11) @(negedge clk);
        chk("t5_pre_rst_pass", 32'(pass_count), 32'd3);
        chk("t5_pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        chk("t5_rst_aborted", 32'(aborted), 32'd0);
        chk("t5_rst_pass", 32'(pass_count), 32'd0);
        chk("t5_rst_fail", 32'(fail_count), 32'd0);
        chk("t5_rst_cmd", 32'({lb.send_1_cmd_send, lb.send_2_cmd_send}), 32'd0);
        chk("t5_rst_addr_1", 32'(lb.send_1_start_ram_addr), 32'(A1));
        chk("t5_rst_addr_2", 32'(lb.send_2_start_ram_addr), 32'(A2));
        push4();
        start_run();
        wait_done();
        chk("t5_pass", 32'(pass_count), 32'd4);
        chk("t5_fail", 32'(fail_count), 32'd0);
        chk("t5_q_drained", 32'(exp_q.size()), 32'd0);
        echo_en = 1'b0;

        // data_saved_2 held high for 50 cycles counts once; a start while busy is ignored.
        push4();
        start_run();
        wait_cmd(port);
        repeat (3) @(negedge clk);
        man_ds2 = 1'b1;
        @(negedge clk);
        chk("t6_first_edge", 32'(pass_count), 32'd1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t6_busy_start_busy", 32'(busy), 32'd1);
        chk("t6_busy_start_pass", 32'(pass_count), 32'd1);
        repeat (43) @(negedge clk);
        man_ds2 = 1'b0;
        wait_done();
        chk("t6_pass", 32'(pass_count), 32'd1);
        chk("t6_fail", 32'(fail_count), 32'd3);
        chk("t6_q_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
